fpga_conf_spi: RTL and testbench

Configuration receiver and mode sequencer for the FPGA top level. It takes the ARM's SPI configuration link, oversamples it on the system clock, and decodes fixed-length command words into a bank of configuration registers. It also provides read-back of those registers on `miso`. The `major_mode` value it drives into the top-level output muxes changes only at a boundary that the active mode declares safe, so a mode switch cannot glitch the carrier.

---
 rtl/fpga_conf_spi.sv | 174 +++++++++++++++++
 tb/tb_fpga_conf_spi.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fpga_conf_spi.sv
// SPI configuration receiver: oversampled frame decode into a register bank,
// register read-back on miso, and major_mode switching gated to safe points.
module fpga_conf_spi #(
  parameter int WORD_W      = 16,
  parameter int CMD_W       = 4,
  parameter int DATA_W      = 12,
  parameter int NUM_REGS    = 4,
  parameter int MODE_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         pck0,
  input  logic                         rst,
  input  logic                         spck,
  input  logic                         mosi,
  input  logic                         ncs,
  output logic                         miso,
  input  logic                         mode_safe,
  output logic [MODE_W-1:0]            major_mode,
  output logic [NUM_REGS*DATA_W-1:0]   conf_regs,
  output logic                         cmd_strobe,
  output logic                         err_len
);

  localparam int RD_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = $clog2(WORD_W + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(WORD_W + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORD_W);
  localparam logic [DATA_W-1:0] REG0_RST = {{MODE_W{1'b1}}, {(DATA_W-MODE_W){1'b0}}};

  logic [SYNC_STAGES-1:0] spck_sync_q, spck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
  logic spck_ed_q, spck_ed_d, ncs_ed_q, ncs_ed_d;
  logic spck_rise_q, spck_rise_d, spck_fall_q, spck_fall_d;
  logic ncs_rise_q, ncs_rise_d, ncs_fall_q, ncs_fall_d;
  logic armed_q, armed_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_reg_q, shift_reg_d;
  logic [WORD_W-1:0] tx_shift_q, tx_shift_d;
  logic [RD_W-1:0]   rd_sel_q, rd_sel_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [MODE_W-1:0] major_mode_q, major_mode_d;
  logic cmd_strobe_q, cmd_strobe_d, err_len_q, err_len_d;

  logic spck_s, mosi_s, ncs_s;
  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] data;
  logic [WORD_W-1:0] tx_load;

  assign spck_s = spck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
  assign cmd    = shift_reg_q[WORD_W-1 -: CMD_W];
  assign data   = shift_reg_q[DATA_W-1:0];

  always_comb begin
    spck_sync_d    = spck_sync_q;
    mosi_sync_d    = mosi_sync_q;
    ncs_sync_d     = ncs_sync_q;
    spck_sync_d[0] = spck;
    mosi_sync_d[0] = mosi;
    ncs_sync_d[0]  = ncs;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      spck_sync_d[i] = spck_sync_q[i-1];
      mosi_sync_d[i] = mosi_sync_q[i-1];
      ncs_sync_d[i]  = ncs_sync_q[i-1];
    end
    spck_ed_d = spck_s;
    ncs_ed_d  = ncs_s;
    armed_d   = armed_q | ncs_s;

    // Edge events are registered; gating by armed_q here drops a frame that
    // straddles reset release, including its closing ncs edge.
    ncs_rise_d  = ncs_s & ~ncs_ed_q & armed_q;
    ncs_fall_d  = ~ncs_s & ncs_ed_q;
    spck_rise_d = spck_s & ~spck_ed_q & ~ncs_s & armed_q;
    spck_fall_d = ~spck_s & spck_ed_q & ~ncs_s;

    tx_load = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_sel_q == RD_W'(k)) tx_load = {CMD_W'(k + 1), regs_q[k]};
    end

    bit_cnt_d    = bit_cnt_q;
    shift_reg_d  = shift_reg_q;
    tx_shift_d   = tx_shift_q;
    rd_sel_d     = rd_sel_q;
    regs_d       = regs_q;
    cmd_strobe_d = 1'b0;
    err_len_d    = 1'b0;

    if (ncs_fall_q) begin
      bit_cnt_d  = '0;
      tx_shift_d = tx_load;
    end else begin
      if (spck_rise_q) begin
        shift_reg_d = {shift_reg_q[WORD_W-2:0], mosi_s};
        if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
      if (spck_fall_q) tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
    end

    if (ncs_rise_q) begin
      if (bit_cnt_q != CNT_FULL) begin
        err_len_d = 1'b1;
      end else if (cmd == {CMD_W{1'b1}}) begin
        rd_sel_d     = data[RD_W-1:0];
        cmd_strobe_d = 1'b1;
      end else begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (cmd == CMD_W'(k + 1)) begin
            regs_d[k]    = data;
            cmd_strobe_d = 1'b1;
          end
        end
      end
    end

    // regs_d makes a write coincident with mode_safe take effect on the same edge.
    major_mode_d = major_mode_q;
    if (mode_safe || (major_mode_q == {MODE_W{1'b1}}))
      major_mode_d = regs_d[0][DATA_W-1 -: MODE_W];
  end

  always_ff @(posedge pck0) begin
    if (rst) begin
      spck_sync_q  <= '0;
      mosi_sync_q  <= '0;
      ncs_sync_q   <= '0;
      spck_ed_q    <= 1'b0;
      ncs_ed_q     <= 1'b0;
      spck_rise_q  <= 1'b0;
      spck_fall_q  <= 1'b0;
      ncs_rise_q   <= 1'b0;
      ncs_fall_q   <= 1'b0;
      armed_q      <= 1'b0;
      bit_cnt_q    <= '0;
      shift_reg_q  <= '0;
      tx_shift_q   <= '0;
      rd_sel_q     <= '0;
      regs_q       <= '0;
      regs_q[0]    <= REG0_RST;
      major_mode_q <= {MODE_W{1'b1}};
      cmd_strobe_q <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      spck_sync_q  <= spck_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      ncs_sync_q   <= ncs_sync_d;
      spck_ed_q    <= spck_ed_d;
      ncs_ed_q     <= ncs_ed_d;
      spck_rise_q  <= spck_rise_d;
      spck_fall_q  <= spck_fall_d;
      ncs_rise_q   <= ncs_rise_d;
      ncs_fall_q   <= ncs_fall_d;
      armed_q      <= armed_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_reg_q  <= shift_reg_d;
      tx_shift_q   <= tx_shift_d;
      rd_sel_q     <= rd_sel_d;
      regs_q       <= regs_d;
      major_mode_q <= major_mode_d;
      cmd_strobe_q <= cmd_strobe_d;
      err_len_q    <= err_len_d;
    end
  end

  assign miso       = tx_shift_q[WORD_W-1];
  assign major_mode = major_mode_q;
  assign conf_regs  = regs_q;
  assign cmd_strobe = cmd_strobe_q;
  assign err_len    = err_len_q;

endmodule

// File: tb/tb_fpga_conf_spi.sv
// Directed bench for fpga_conf_spi: expected events are queued at stimulus time
// and matched by a monitor whenever cmd_strobe or err_len pulses.
module tb_fpga_conf_spi;
  localparam int WORD_W = 16;
  localparam int S      = 2;
  localparam int HALF   = 5;
  localparam int K_STB  = 1;
  localparam int K_ERR  = 2;

  logic pck0 = 1'b0;
  logic rst, spck, mosi, ncs, mode_safe;
  logic miso, cmd_strobe, err_len;
  logic [2:0]  major_mode;
  logic [47:0] conf_regs;

  fpga_conf_spi dut (
    .pck0(pck0), .rst(rst), .spck(spck), .mosi(mosi), .ncs(ncs), .miso(miso),
    .mode_safe(mode_safe), .major_mode(major_mode), .conf_regs(conf_regs),
    .cmd_strobe(cmd_strobe), .err_len(err_len)
  );

  always #5 pck0 = ~pck0;

  int cyc = 0;
  always @(posedge pck0) cyc = cyc + 1;

  typedef struct {
    int          kind;
    logic [47:0] regs;
    logic [2:0]  mode;
    int          t;
  } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge pck0) begin
    if (cmd_strobe === 1'b1 || err_len === 1'b1) begin
      ev_t e;
      int  k;
      k = (cmd_strobe === 1'b1 ? K_STB : 0) + (err_len === 1'b1 ? K_ERR : 0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", k, 0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", k, e.kind);
        check("event_regs", conf_regs, e.regs);
        check("event_mode", major_mode, e.mode);
        check("event_latency", cyc - e.t, S + 2);
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge pck0);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    wait_n(HALF);
    m = miso;
    spck = 1'b1;
    wait_n(HALF);
    spck = 1'b0;
  endtask

  task automatic frame(input logic [WORD_W-1:0] w, input int nbits, input int kind,
                       input logic [47:0] eregs, input logic [2:0] emode,
                       input bit safe, output logic [WORD_W-1:0] rx);
    ev_t e;
    rx  = '0;
    ncs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      logic b, m;
      b = (i < WORD_W) ? w[WORD_W-1-i] : 1'b0;
      spi_bit(b, m);
      if (i < WORD_W) rx[WORD_W-1-i] = m;
    end
    wait_n(HALF);
    if (kind != 0) begin
      e.kind = kind; e.regs = eregs; e.mode = emode; e.t = cyc;
      exp_q.push_back(e);
    end
    ncs = 1'b1;
    if (safe) begin
      wait_n(S + 1);
      mode_safe = 1'b1;
      wait_n(1);
      mode_safe = 1'b0;
      wait_n(8);
    end else begin
      wait_n(12);
    end
  endtask

  initial begin
    logic [WORD_W-1:0] rx;
    logic m;
    rst = 1'b1; spck = 1'b0; mosi = 1'b0; ncs = 1'b1; mode_safe = 1'b0;
    wait_n(3);
    check("rst_regs", conf_regs, 48'h000_000_000_E00);
    check("rst_mode", major_mode, 3'd7);
    check("rst_miso", miso, 1'b0);
    check("rst_pulses", {cmd_strobe, err_len}, 2'b00);
    rst = 1'b0;
    wait_n(10);

    // Write leaving the off mode applies immediately
    frame(16'h1ABC, 16, K_STB, 48'h000_000_000_ABC, 3'd5, 1'b0, rx);
    check("write_mode_now", major_mode, 3'd5);

    // Deferred switch waits for mode_safe
    frame(16'h1400, 16, K_STB, 48'h000_000_000_400, 3'd5, 1'b0, rx);
    wait_n(50);
    check("deferred_hold", major_mode, 3'd5);
    mode_safe = 1'b1;
    wait_n(1);
    mode_safe = 1'b0;
    check("deferred_switch", major_mode, 3'd2);

    // Bad lengths
    frame(16'h2123, 15, K_ERR, 48'h000_000_000_400, 3'd2, 1'b0, rx);
    frame(16'h2123, 17, K_ERR, 48'h000_000_000_400, 3'd2, 1'b0, rx);
    check("badlen_regs", conf_regs, 48'h000_000_000_400);

    // Read-back of register 2
    frame(16'h3055, 16, K_STB, 48'h000_055_000_400, 3'd2, 1'b0, rx);
    frame(16'hF002, 16, K_STB, 48'h000_055_000_400, 3'd2, 1'b0, rx);
    frame(16'h0000, 16, 0,     48'h0,               3'd0, 1'b0, rx);
    check("readback_miso", rx, 16'h3055);
    check("nop_regs", conf_regs, 48'h000_055_000_400);

    // Reset mid-frame
    ncs = 1'b0;
    for (int i = 0; i < 8; i++) spi_bit(1'b1, m);
    rst = 1'b1;
    wait_n(3);
    rst = 1'b0;
    wait_n(2);
    for (int i = 0; i < 8; i++) spi_bit(1'b1, m);
    wait_n(HALF);
    ncs = 1'b1;
    wait_n(12);
    check("midrst_regs", conf_regs, 48'h000_000_000_E00);
    check("midrst_mode", major_mode, 3'd7);
    frame(16'h2777, 16, K_STB, 48'h000_000_777_E00, 3'd7, 1'b0, rx);

    // Coincident mode_safe, then invalid command
    frame(16'h1400, 16, K_STB, 48'h000_000_777_400, 3'd2, 1'b0, rx);
    frame(16'h1200, 16, K_STB, 48'h000_000_777_200, 3'd1, 1'b1, rx);
    check("coincident_mode", major_mode, 3'd1);
    frame(16'h8123, 16, 0, 48'h0, 3'd0, 1'b0, rx);
    check("invalid_regs", conf_regs, 48'h000_000_777_200);
    check("invalid_mode", major_mode, 3'd1);

    wait_n(20);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
